// File: rtl/hex_display_reader.sv
// Seven-segment monitor: decodes the eight active-low HEX buses back into a 32-bit value,
// publishes it once stable and checks that successive publishes step by +1.

module hex_seg_decode (
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       ok
);
    always_comb begin
        nib = 4'h0;
        ok  = 1'b1;
        case (seg)
            7'b1000000:             nib = 4'h0;
            7'b1111001, 7'b1111011: nib = 4'h1;
            7'b0100100:             nib = 4'h2;
            7'b0110000:             nib = 4'h3;
            7'b0011001:             nib = 4'h4;
            7'b0010010:             nib = 4'h5;
            7'b0000010:             nib = 4'h6;
            7'b1111000:             nib = 4'h7;
            7'b0000000:             nib = 4'h8;
            7'b0011000:             nib = 4'h9;
            7'b0001000:             nib = 4'ha;
            7'b0000011:             nib = 4'hb;
            7'b0100111:             nib = 4'hc;
            7'b0100001:             nib = 4'hd;
            7'b0000110:             nib = 4'he;
            7'b0001110:             nib = 4'hf;
            default:                ok  = 1'b0;
        endcase
    end
endmodule

module hex_display_reader #(
    parameter int STABLE_CYCLES = 2,
    parameter int PAUSE_CYCLES  = 8
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [6:0]  HEX0,
    input  logic [6:0]  HEX1,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX5,
    input  logic [6:0]  HEX6,
    input  logic [6:0]  HEX7,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [7:0]  digit_err,
    output logic        seq_err,
    output logic        paused,
    output logic [15:0] step_count,
    output logic [7:0]  jump_count
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(PAUSE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [IW-1:0] PAUSE_LAST = IW'(PAUSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, PAUSED} state_t;

    state_t          state;
    logic [7:0][6:0] hex_in, hex_q;
    logic [7:0][3:0] nib;
    logic [7:0]      ok;
    logic            samp_vld;
    logic [31:0]     cand, prev_cand;
    logic            cand_ok;
    logic [SW-1:0]   stab_cnt, stab_next;
    logic [IW-1:0]   idle_cnt;
    logic            publish, is_step;

    assign hex_in = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    for (genvar i = 0; i < 8; i++) begin : g_dec
        hex_seg_decode u_dec (.seg(hex_q[i]), .nib(nib[i]), .ok(ok[i]));
    end

    // samp_vld masks the cleared sample registers until the first real sample lands
    assign cand    = nib;
    assign cand_ok = samp_vld & (&ok);
    assign is_step = (cand == value + 32'd1);

    always_comb begin
        stab_next = '0;
        if (!cand_ok)
            stab_next = '0;
        else if (cand != prev_cand)
            stab_next = SW'(1);
        else if (stab_cnt == STABLE_MAX)
            stab_next = stab_cnt;
        else
            stab_next = stab_cnt + SW'(1);
    end

    assign publish = (stab_next == STABLE_MAX) && ((state == IDLE) || (cand != value));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hex_q       <= '0;
            samp_vld    <= 1'b0;
            prev_cand   <= '0;
            stab_cnt    <= '0;
            idle_cnt    <= '0;
            state       <= IDLE;
            value       <= '0;
            value_valid <= 1'b0;
            digit_err   <= '0;
            seq_err     <= 1'b0;
            paused      <= 1'b0;
            step_count  <= '0;
            jump_count  <= '0;
        end else begin
            hex_q       <= hex_in;
            samp_vld    <= 1'b1;
            prev_cand   <= cand;
            stab_cnt    <= stab_next;
            digit_err   <= samp_vld ? ~ok : 8'h00;
            value_valid <= publish;
            seq_err     <= 1'b0;
            if (publish) begin
                value    <= cand;
                idle_cnt <= '0;
                paused   <= 1'b0;
                state    <= TRACK;
                if (state != IDLE) begin
                    if (is_step) begin
                        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                    end else begin
                        seq_err <= 1'b1;
                        if (jump_count != 8'hFF) jump_count <= jump_count + 8'd1;
                    end
                end
            end else begin
                case (state)
                    TRACK: begin
                        idle_cnt <= idle_cnt + IW'(1);
                        if (idle_cnt == PAUSE_LAST) begin
                            state  <= PAUSED;
                            paused <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
